vector_lsu_multi: RTL and testbench

Parametrised next-generation vector load/store unit. Accepts one vector memory command at a time with base, stride and length, and issues one memory request per element with up to MAX_OUTSTANDING requests in flight. Store data is sourced from a streaming interface. Load responses are returned, tagged with their element index, to the vector register write-back path. Sits between the execution unit and the memory request arbiter.

---
 rtl/vector_lsu_multi.sv | 208 ++++++++++++++++++++
 tb/tb_vector_lsu_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lsu_multi.sv
// Vector load/store unit: one strided command at a time, one memory request per element,
// bounded in-flight requests. Define VLSU_STRIDE_EN to honour cmd_stride (default: unit stride).
module vector_lsu_multi #(
    parameter int MAX_VLEN        = 64,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int IDX_W           = $clog2(MAX_VLEN),
    parameter int LEN_W           = $clog2(MAX_VLEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_is_store,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W-1:0]   cmd_stride,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                st_vld,
    output logic                st_rdy,
    input  logic [DATA_W-1:0]   st_data,
    output logic                mem_req_vld,
    input  logic                mem_req_rdy,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [IDX_W-1:0]    mem_req_id,
    output logic [DATA_W/8-1:0] mem_req_be,
    output logic [DATA_W-1:0]   mem_req_data,
    input  logic                mem_rsp_vld,
    input  logic [IDX_W-1:0]    mem_rsp_id,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                ld_vld,
    output logic [IDX_W-1:0]    ld_idx,
    output logic [DATA_W-1:0]   ld_data,
    output logic                done,
    output logic                err
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              req_vld_q, req_vld_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [IDX_W-1:0]  req_id_q, req_id_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              ld_vld_q, ld_vld_d;
    logic [IDX_W-1:0]  ld_idx_q, ld_idx_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept, grant, rsp_ok, load;
    logic              cur_store;
    logic [LEN_W-1:0]  len_in, cur_len, cur_cnt;
    logic [ADDR_W-1:0] stride_in, cur_addr, cur_stride;

`ifdef VLSU_STRIDE_EN
    assign stride_in = cmd_stride;
`else
    logic unused_stride;
    assign stride_in     = ADDR_W'(DATA_W / 8);
    assign unused_stride = ^cmd_stride;
`endif

    assign accept = (state_q == IDLE) && cmd_vld;
    assign grant  = req_vld_q && mem_req_rdy;
    assign rsp_ok = mem_rsp_vld && (outst_q != '0);
    assign len_in = (cmd_len > LEN_W'(MAX_VLEN)) ? LEN_W'(MAX_VLEN) : cmd_len;

    // Element 0 is issued in the accept cycle itself, so its fields come straight from the command.
    assign cur_store  = accept ? cmd_is_store : is_store_q;
    assign cur_len    = accept ? len_in       : len_q;
    assign cur_cnt    = accept ? '0           : issue_cnt_q;
    assign cur_addr   = accept ? cmd_base     : addr_q;
    assign cur_stride = accept ? stride_in    : stride_q;

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        stride_d    = stride_q;
        addr_d      = addr_q;
        req_vld_d   = req_vld_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_id_d    = req_id_q;
        req_data_d  = req_data_q;
        ld_vld_d    = 1'b0;
        ld_idx_d    = ld_idx_q;
        ld_data_d   = ld_data_q;
        done_d      = 1'b0;
        st_rdy      = 1'b0;

        // In-flight count after this cycle's grant and response; new loads must keep it below the cap.
        outst_d = accept ? '0 : outst_q + OUT_W'(grant) - OUT_W'(rsp_ok);
        load    = (accept || (state_q == ISSUE)) && (cur_cnt < cur_len)
                  && (!req_vld_q || grant) && (outst_d < OUT_W'(MAX_OUTSTANDING))
                  && (!cur_store || st_vld);

        if (accept) begin
            is_store_d  = cmd_is_store;
            len_d       = len_in;
            stride_d    = stride_in;
            addr_d      = cmd_base;
            issue_cnt_d = '0;
            rsp_cnt_d   = '0;
            state_d     = (len_in == '0) ? DRAIN : ISSUE;
        end

        if (load) begin
            req_vld_d   = 1'b1;
            req_we_d    = cur_store;
            req_addr_d  = cur_addr;
            req_id_d    = cur_cnt[IDX_W-1:0];
            req_data_d  = cur_store ? st_data : '0;
            addr_d      = cur_addr + cur_stride;
            issue_cnt_d = cur_cnt + LEN_W'(1);
            st_rdy      = cur_store;
        end else if (grant) begin
            req_vld_d = 1'b0;
        end

        if (rsp_ok) begin
            rsp_cnt_d = rsp_cnt_q + LEN_W'(1);
            ld_vld_d  = !is_store_q;
            ld_idx_d  = mem_rsp_id;
            ld_data_d = mem_rsp_data;
        end
        err_d = (err_q && !accept) || (mem_rsp_vld && !rsp_ok);

        if ((state_q == ISSUE) && grant && (issue_cnt_q == len_q)) begin
            state_d = DRAIN;
        end
        if ((state_q == DRAIN) && (rsp_cnt_d == len_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            req_vld_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_id_q    <= '0;
            req_data_q  <= '0;
            ld_vld_q    <= 1'b0;
            ld_idx_q    <= '0;
            ld_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            stride_q    <= stride_d;
            addr_q      <= addr_d;
            outst_q     <= outst_d;
            req_vld_q   <= req_vld_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_id_q    <= req_id_d;
            req_data_q  <= req_data_d;
            ld_vld_q    <= ld_vld_d;
            ld_idx_q    <= ld_idx_d;
            ld_data_q   <= ld_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_rdy      = (state_q == IDLE);
    assign mem_req_vld  = req_vld_q;
    assign mem_req_we   = req_we_q;
    assign mem_req_addr = req_addr_q;
    assign mem_req_id   = req_id_q;
    assign mem_req_be   = {(DATA_W/8){req_vld_q}};
    assign mem_req_data = req_data_q;
    assign ld_vld       = ld_vld_q;
    assign ld_idx       = ld_idx_q;
    assign ld_data      = ld_data_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_vector_lsu_multi.sv
// Directed self-checking bench for vector_lsu_multi: a per-cycle task samples outputs on the
// falling edge and drives responses and store data just after the rising edge.
module tb_vector_lsu_multi;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;
    localparam int LEN_W  = 7;
    localparam logic [63:0] SENT = 64'hBAD0_BAD0_BAD0_BAD0;
`ifdef VLSU_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    logic              clk, reset;
    logic              cmd_vld, cmd_rdy, cmd_is_store;
    logic [ADDR_W-1:0] cmd_base, cmd_stride;
    logic [LEN_W-1:0]  cmd_len;
    logic              st_vld, st_rdy;
    logic [DATA_W-1:0] st_data;
    logic              mem_req_vld, mem_req_rdy, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [IDX_W-1:0]  mem_req_id;
    logic [7:0]        mem_req_be;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_vld;
    logic [IDX_W-1:0]  mem_rsp_id;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              ld_vld;
    logic [IDX_W-1:0]  ld_idx;
    logic [DATA_W-1:0] ld_data;
    logic              done, err;

    vector_lsu_multi dut (
        .clk(clk), .reset(reset),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_is_store(cmd_is_store),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
        .st_vld(st_vld), .st_rdy(st_rdy), .st_data(st_data),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id), .mem_req_be(mem_req_be),
        .mem_req_data(mem_req_data),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
        .ld_vld(ld_vld), .ld_idx(ld_idx), .ld_data(ld_data),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [63:0] g_addr[$];
    logic [63:0] g_data[$];
    int          g_id[$];
    bit          g_we[$];
    logic [7:0]  g_be[$];
    int          g_cyc[$];
    int          l_idx[$];
    logic [63:0] l_data[$];
    int          done_cnt, done_cyc, ld_at_done;
    bit          done_with_ld;
    bit          auto_rsp;
    int          pend_id[$];
    int          pend_due[$];
    bit          st_mode;
    int          st_idx, st_n;
    int          acc_cyc;

    function automatic logic [63:0] rsp_val(int id);
        return 64'hA5A5_0000_0000_0000 + 64'(id);
    endfunction

    function automatic logic [63:0] ga(int i);
        return (i < g_addr.size()) ? g_addr[i] : SENT;
    endfunction
    function automatic logic [63:0] gd(int i);
        return (i < g_data.size()) ? g_data[i] : SENT;
    endfunction
    function automatic logic [63:0] gi(int i);
        return (i < g_id.size()) ? 64'(g_id[i]) : SENT;
    endfunction
    function automatic logic [63:0] li(int i);
        return (i < l_idx.size()) ? 64'(l_idx[i]) : SENT;
    endfunction
    function automatic logic [63:0] ldv(int i);
        return (i < l_data.size()) ? l_data[i] : SENT;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the next cycle's inputs after the rising edge.
    task automatic cycle();
        bit st_hs;
        int id;
        @(negedge clk);
        if (mem_req_vld && mem_req_rdy) begin
            g_addr.push_back(mem_req_addr);
            g_data.push_back(mem_req_data);
            g_id.push_back(int'(mem_req_id));
            g_we.push_back(mem_req_we);
            g_be.push_back(mem_req_be);
            g_cyc.push_back(cyc);
            if (auto_rsp) begin
                pend_id.push_back(int'(mem_req_id));
                pend_due.push_back(cyc + 2);
            end
        end
        if (ld_vld) begin
            l_idx.push_back(int'(ld_idx));
            l_data.push_back(ld_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            ld_at_done   = l_idx.size();
            done_with_ld = ld_vld;
        end
        st_hs = st_vld && st_rdy;
        @(posedge clk);
        #1;
        cyc++;
        mem_rsp_vld = 1'b0;
        if (pend_id.size() > 0 && pend_due[0] <= cyc) begin
            id = pend_id.pop_front();
            void'(pend_due.pop_front());
            mem_rsp_vld  = 1'b1;
            mem_rsp_id   = IDX_W'(id);
            mem_rsp_data = rsp_val(id);
        end
        if (st_hs) st_idx++;
        st_vld  = st_mode && (cyc % 2 == 0) && (st_idx < st_n);
        st_data = 64'h5700_0000_0000_0000 + 64'(st_idx);
    endtask

    task automatic clear_logs();
        g_addr.delete(); g_data.delete(); g_id.delete(); g_we.delete(); g_be.delete();
        g_cyc.delete(); l_idx.delete(); l_data.delete();
        done_cnt = 0; done_cyc = -1; ld_at_done = -1; done_with_ld = 1'b0;
    endtask

    task automatic send_cmd(input bit is_store, input logic [63:0] base,
                            input logic [63:0] stride, input int len);
        check("cmd_rdy_before_accept", cmd_rdy, 1);
        cmd_vld      = 1'b1;
        cmd_is_store = is_store;
        cmd_base     = base;
        cmd_stride   = stride;
        cmd_len      = LEN_W'(len);
        cycle();
        cmd_vld = 1'b0;
        acc_cyc = cyc - 1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        check("done_within_budget", 64'(done_cnt != 0), 1);
    endtask

    initial begin
        logic [63:0] s;
        logic [63:0] held;

        reset = 1'b1;
        cmd_vld = 1'b0; cmd_is_store = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0;
        st_vld = 1'b0; st_data = '0; mem_req_rdy = 1'b0;
        mem_rsp_vld = 1'b0; mem_rsp_id = '0; mem_rsp_data = '0;
        auto_rsp = 1'b0; st_mode = 1'b0; st_idx = 0; st_n = 0;
        clear_logs();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_mem_req_vld", mem_req_vld, 0);
        check("rst_mem_req_be", mem_req_be, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_st_rdy", st_rdy, 0);
        check("rst_ld_vld", ld_vld, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        repeat (2) cycle();

        // Unit-stride load, responses in order two cycles after each grant.
        clear_logs();
        auto_rsp = 1'b1;
        mem_req_rdy = 1'b1;
        send_cmd(1'b0, 64'h1000, 64'h8, 4);
        check("t1_first_vld_latency", mem_req_vld, 1);
        check("t1_first_addr", mem_req_addr, 64'h1000);
        wait_done(40);
        repeat (3) cycle();
        check("t1_grants", g_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", ga(i), 64'h1000 + 64'(8 * i));
            check("t1_id", gi(i), 64'(i));
            check("t1_ld_idx", li(i), 64'(i));
            check("t1_ld_data", ldv(i), rsp_val(i));
        end
        check("t1_we", (g_we.size() > 0) ? 64'(g_we[0]) : SENT, 0);
        check("t1_load_data_zero", gd(0), 0);
        check("t1_be", (g_be.size() > 0) ? 64'(g_be[0]) : SENT, 64'hFF);
        check("t1_back_to_back", (g_cyc.size() == 4) ? 64'(g_cyc[3] - g_cyc[0]) : SENT, 3);
        check("t1_ld_count", l_idx.size(), 4);
        check("t1_done_count", done_cnt, 1);
        check("t1_done_with_last_ld", done_with_ld, 1);

        // Store with a store-data stream valid only every other cycle.
        clear_logs();
        st_mode = 1'b1; st_idx = 0; st_n = 3;
        send_cmd(1'b1, 64'h2000, 64'h40, 3);
        wait_done(60);
        repeat (3) cycle();
        st_mode = 1'b0;
        s = STRIDE_EN ? 64'h40 : 64'h8;
        check("t2_grants", g_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t2_addr", ga(i), 64'h2000 + 64'(i) * s);
            check("t2_data", gd(i), 64'h5700_0000_0000_0000 + 64'(i));
            check("t2_we", (i < g_we.size()) ? 64'(g_we[i]) : SENT, 1);
        end
        check("t2_st_consumed", st_idx, 3);
        check("t2_no_ld", l_idx.size(), 0);
        check("t2_done_count", done_cnt, 1);

        // Outstanding cap: 16 elements, responses withheld.
        clear_logs();
        auto_rsp = 1'b0;
        send_cmd(1'b0, 64'h3000, 64'h8, 16);
        repeat (20) cycle();
        check("t3_grants_at_cap", g_addr.size(), 8);
        check("t3_vld_stalled", mem_req_vld, 0);
        check("t3_stall_addr", mem_req_addr, 64'h3038);
        check("t3_stall_id", mem_req_id, 7);
        held = mem_req_addr;
        repeat (3) cycle();
        check("t3_still_at_cap", g_addr.size(), 8);
        check("t3_addr_stable", mem_req_addr, held);
        pend_id.push_back(0);
        pend_due.push_back(0);
        repeat (4) cycle();
        check("t3_ninth_grant", g_addr.size(), 9);
        check("t3_ninth_addr", ga(8), 64'h3040);
        check("t3_ninth_id", gi(8), 8);
        for (int i = 1; i <= 8; i++) begin
            pend_id.push_back(i);
            pend_due.push_back(0);
        end
        auto_rsp = 1'b1;
        wait_done(100);
        repeat (3) cycle();
        check("t3_grants_total", g_addr.size(), 16);
        check("t3_ld_count", l_idx.size(), 16);
        check("t3_last_ld_idx", li(15), 15);
        check("t3_done_count", done_cnt, 1);

        // Out-of-order responses 3,1,0,2.
        clear_logs();
        auto_rsp = 1'b0;
        send_cmd(1'b0, 64'h4000, 64'h8, 4);
        repeat (6) cycle();
        check("t4_grants", g_addr.size(), 4);
        check("t4_no_early_done", done_cnt, 0);
        pend_id.push_back(3); pend_due.push_back(0);
        pend_id.push_back(1); pend_due.push_back(0);
        pend_id.push_back(0); pend_due.push_back(0);
        pend_id.push_back(2); pend_due.push_back(0);
        wait_done(20);
        repeat (3) cycle();
        check("t4_ld_idx0", li(0), 3);
        check("t4_ld_idx1", li(1), 1);
        check("t4_ld_idx2", li(2), 0);
        check("t4_ld_idx3", li(3), 2);
        check("t4_ld_data0", ldv(0), rsp_val(3));
        check("t4_ld_at_done", ld_at_done, 4);
        check("t4_done_count", done_cnt, 1);

        // Zero length: accept cycle, one DRAIN cycle, then done as IDLE is re-entered.
        clear_logs();
        auto_rsp = 1'b1;
        send_cmd(1'b0, 64'h5000, 64'h8, 0);
        check("t5_busy_in_drain", cmd_rdy, 0);
        wait_done(10);
        check("t5_done_delay", 64'(done_cyc - acc_cyc), 2);
        check("t5_no_req", g_addr.size(), 0);
        check("t5_idle_again", cmd_rdy, 1);
        repeat (2) cycle();

        // Negative stride with address wrap-around.
        clear_logs();
        send_cmd(1'b0, 64'h8, 64'hFFFF_FFFF_FFFF_FFF8, 3);
        wait_done(30);
        repeat (2) cycle();
        s = STRIDE_EN ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'h8;
        check("t6_grants", g_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t6_addr", ga(i), 64'h8 + 64'(i) * s);
        end

        // Length above MAX_VLEN is clamped to 64.
        clear_logs();
        send_cmd(1'b0, 64'h6000, 64'h8, 100);
        wait_done(200);
        repeat (3) cycle();
        check("t7_grants_clamped", g_addr.size(), 64);
        check("t7_last_id", gi(63), 63);
        check("t7_last_addr", ga(63), 64'h61F8);
        check("t7_ld_count", l_idx.size(), 64);

        // Reset after two of six grants, then a stale response.
        clear_logs();
        auto_rsp = 1'b0;
        send_cmd(1'b0, 64'h7000, 64'h8, 6);
        for (int n = 0; n < 10 && g_addr.size() < 2; n++) cycle();
        check("t8_two_grants", g_addr.size(), 2);
        reset = 1'b0;
        #1;
        check("t8_rst_vld", mem_req_vld, 0);
        check("t8_rst_cmd_rdy", cmd_rdy, 1);
        check("t8_rst_addr", mem_req_addr, 0);
        check("t8_rst_done", done, 0);
        check("t8_rst_ld_vld", ld_vld, 0);
        check("t8_rst_err", err, 0);
        repeat (2) cycle();
        reset = 1'b1;
        repeat (5) cycle();
        check("t8_no_done", done_cnt, 0);
        check("t8_no_more_grants", g_addr.size(), 2);
        pend_id.push_back(1);
        pend_due.push_back(0);
        repeat (3) cycle();
        check("t8_stale_err", err, 1);
        check("t8_stale_no_ld", l_idx.size(), 0);
        auto_rsp = 1'b1;
        send_cmd(1'b0, 64'h8000, 64'h8, 1);
        check("t8_err_cleared", err, 0);
        wait_done(20);
        check("t8_done_after_clear", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
